// File: rtl/program_loader.sv
// Packs UART bytes MSB-first into 32-bit words and writes them to consecutive
// instruction-memory words until HALT or overflow. Optional: PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int unsigned INST_WIDTH     = 32,
  parameter int unsigned IM_ADDR_LENGTH = 32,
  parameter int unsigned MAX_WORDS      = 32,
  parameter logic [INST_WIDTH-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic [7:0]                i_rx_data,
  input  logic                      i_rx_done,
  output logic [IM_ADDR_LENGTH-1:0] o_IM_Addr,
  output logic [INST_WIDTH-1:0]     o_IM_Data,
  output logic                      o_IM_We,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_error
);

  localparam int unsigned IdxW = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    StIdle,
    StRecv,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    StCheck,
`endif
    StDone,
    StError
  } state_e;

  state_e                    state_q, state_d;
  logic [1:0]                cnt_q, cnt_d;
  logic [INST_WIDTH-9:0]     shreg_q, shreg_d;
  logic [IdxW-1:0]           idx_q, idx_d;
  logic [IdxW-1:0]           idx_inc;
  logic [IM_ADDR_LENGTH-1:0] addr_q, addr_d;
  logic [INST_WIDTH-1:0]     data_q, data_d;
  logic                      we_q, we_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      error_q, error_d;
  logic                      start_load;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]                csum_q, csum_d;
`endif

  assign idx_inc = idx_q + IdxW'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = 1'b0;
    start_load = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (i_start) start_load = 1'b1;
      end
      StRecv: begin
        // The end-of-load decision is taken in the write cycle itself.
        if (we_q) begin
          idx_d = idx_inc;
          if (data_q == HALT_WORD) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state_d = StCheck;
`else
            state_d = StDone;
`endif
          end else if (idx_inc == IdxW'(MAX_WORDS)) begin
            state_d = StError;
          end
        end
        // A byte landing in the final write cycle belongs to no word.
        if (i_rx_done && (state_d == StRecv)) begin
          shreg_d = {shreg_q[INST_WIDTH-17:0], i_rx_data};
          cnt_d   = cnt_q + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ i_rx_data;
`endif
          if (cnt_q == 2'd3) begin
            we_d   = 1'b1;
            data_d = {shreg_q, i_rx_data};
            addr_d = IM_ADDR_LENGTH'({idx_q, 2'b00});
          end
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      StCheck: begin
        if (i_rx_done) state_d = (i_rx_data == csum_q) ? StDone : StError;
      end
`endif
      StDone, StError: begin
        if (i_start) start_load = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (start_load) begin
      state_d = StRecv;
      cnt_d   = 2'd0;
      shreg_d = '0;
      idx_d   = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_d  = 8'h00;
`endif
    end
  end

  always_comb begin
    busy_d  = (state_d == StRecv);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    busy_d  = busy_d || (state_d == StCheck);
`endif
    done_d  = (state_d == StDone);
    error_d = (state_d == StError);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      shreg_q <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign o_IM_Addr = addr_q;
  assign o_IM_Data = data_q;
  assign o_IM_We   = we_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_error   = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a byte-stream model predicts writes and
// final status; a negedge monitor checks every write strobe against the queue.
module tb_program_loader;

  localparam int unsigned MaxWords = 4;
  localparam logic [31:0] Halt     = 32'hFFFF_FFFF;
  localparam int StBusy = 0;
  localparam int StDone = 1;
  localparam int StErr  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_done = 1'b0;
  logic [31:0] o_IM_Addr;
  logic [31:0] o_IM_Data;
  logic        o_IM_We;
  logic        o_busy;
  logic        o_done;
  logic        o_error;

  program_loader #(
    .INST_WIDTH    (32),
    .IM_ADDR_LENGTH(32),
    .MAX_WORDS     (MaxWords),
    .HALT_WORD     (Halt)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (i_start),
    .i_rx_data(i_rx_data),
    .i_rx_done(i_rx_done),
    .o_IM_Addr(o_IM_Addr),
    .o_IM_Data(o_IM_Data),
    .o_IM_We  (o_IM_We),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_error  (o_error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int last_we_cycle = -1;
  int done_rise = -1;
  int err_rise = -1;
  logic we_prev = 1'b0;
  logic done_prev = 1'b0;
  logic err_prev = 1'b0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;

  always @(posedge clk) cycle++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe is matched against the expected-write queue.
  always @(negedge clk) begin
    if (o_IM_We) begin
      chk("we_single_cycle", {63'd0, we_prev}, 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h, required no write",
                 o_IM_Addr, o_IM_Data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_addr", {32'd0, o_IM_Addr}, {32'd0, mon_e[63:32]});
        chk("write_data", {32'd0, o_IM_Data}, {32'd0, mon_e[31:0]});
      end
      last_we_cycle = cycle;
    end
    if (o_done && !done_prev) done_rise = cycle;
    if (o_error && !err_prev) err_rise = cycle;
    we_prev   = o_IM_We;
    done_prev = o_done;
    err_prev  = o_error;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    i_rx_data = b;
    i_rx_done = 1'b1;
    tick();
    i_rx_done = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    for (int i = 0; i < n; i++) begin
      i_rx_done = ~i_rx_done;
      i_rx_data = 8'(i + 8'h5A);
      tick();
    end
    i_rx_done = 1'b0;
    rst = 1'b1;
  endtask

  // Reference: group bytes in fours, write sequentially, stop at HALT or capacity.
  task automatic model(input logic [7:0] b[$], output int st);
    int k = 0;
    int nw = 0;
    logic [31:0] w;
    logic [7:0] x = 8'h00;
    bit halted = 0;
    st = StBusy;
    while (st == StBusy && !halted && k + 4 <= b.size()) begin
      w = {b[k], b[k+1], b[k+2], b[k+3]};
      x = x ^ b[k] ^ b[k+1] ^ b[k+2] ^ b[k+3];
      exp_q.push_back({32'(nw * 4), w});
      nw++;
      k += 4;
      if (w == Halt) halted = 1;
      else if (nw == int'(MaxWords)) st = StErr;
    end
    if (halted) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      if (k < b.size()) st = (b[k] == x) ? StDone : StErr;
`else
      st = StDone;
`endif
    end
  endtask

  task automatic run_load(input string name, input logic [7:0] b[$], input int gapmax,
                          output int st);
    logic [31:0] w = 32'd0;
    int gap;
    model(b, st);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk({name, "_busy_after_start"}, {63'd0, o_busy}, 64'd1);
    for (int k = 0; k < b.size(); k++) begin
      w = {w[23:0], b[k]};
      gap = $urandom_range(0, gapmax);
      // The checksum byte is only listened for once the halt write is done.
      if ((k % 4 == 3) && (w == Halt)) gap = 2;
      send(b[k], gap);
    end
    repeat (3) tick();
    chk({name, "_done"},  {63'd0, o_done},  {63'd0, st == StDone});
    chk({name, "_error"}, {63'd0, o_error}, {63'd0, st == StErr});
    chk({name, "_busy"},  {63'd0, o_busy},  {63'd0, st == StBusy});
    chk({name, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [7:0] bq[$];
    logic [7:0] x;
    int st;

    // Reset with strobes toggling.
    do_reset(3);
    rst = 1'b0;
    chk("reset_addr",  {32'd0, o_IM_Addr}, 64'd0);
    chk("reset_data",  {32'd0, o_IM_Data}, 64'd0);
    chk("reset_we",    {63'd0, o_IM_We},   64'd0);
    chk("reset_busy",  {63'd0, o_busy},    64'd0);
    chk("reset_done",  {63'd0, o_done},    64'd0);
    chk("reset_error", {63'd0, o_error},   64'd0);
    rst = 1'b1;
    tick();

`ifndef PROGRAM_LOADER_CHECKSUM_EN
    bq = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    done_rise = -1;
    run_load("basic", bq, 1, st);
    chk("basic_done_timing", 64'(done_rise), 64'(last_we_cycle + 1));
`else
    bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h04};
    run_load("csum_good", bq, 1, st);
    bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h05};
    run_load("csum_bad", bq, 1, st);
`endif

    // Overflow: five non-halt words into four slots.
    bq = {};
    for (int i = 0; i < 20; i++) bq.push_back(8'(8'h10 + i));
    err_rise = -1;
    run_load("overflow", bq, 1, st);
    chk("overflow_error_timing", 64'(err_rise), 64'(last_we_cycle + 1));

    // Reset mid-word: partial bytes must not leak into the next word.
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    send(8'hAA, 0);
    send(8'hBB, 0);
    do_reset(1);
    chk("midreset_busy", {63'd0, o_busy}, 64'd0);
    chk("midreset_we",   {63'd0, o_IM_We}, 64'd0);
    bq = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load("midreset_reload", bq, 0, st);
    do_reset(1);

    // Back-to-back strobes on eight consecutive cycles.
    bq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    run_load("b2b", bq, 0, st);
    do_reset(1);

    // Randomized programs.
    for (int r = 0; r < 12; r++) begin
      int nw;
      bq = {};
      x = 8'h00;
      nw = $urandom_range(1, 6);
      for (int i = 0; i < nw * 4; i++) begin
        bq.push_back(8'($urandom_range(0, 255)));
        x = x ^ bq[$];
      end
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 4; i++) bq.push_back(8'hFF);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if ($urandom_range(0, 1) == 1) bq.push_back(x);
        else bq.push_back(8'($urandom_range(0, 255)));
`endif
      end
      run_load("random", bq, 2, st);
      if (st == StBusy) do_reset(1);
    end

    chk("final_pending_writes", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
